// File: rtl/elliptic_curve_structs.sv
// Shared curve types, MSM state enum and GF(p) helpers.
// Curve: y^2 = x^3 + x + 250 over GF(251).
package elliptic_curve_structs;
  localparam int unsigned P_WIDTH      = 8;
  localparam int unsigned SCALAR_WIDTH = 8;
  localparam logic [P_WIDTH-1:0] P_MOD   = 8'd251;
  localparam logic [P_WIDTH-1:0] CURVE_A = 8'd1;

  typedef struct packed {
    logic [P_WIDTH-1:0] x;
    logic [P_WIDTH-1:0] y;
  } curve_point_t;

  typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, ACC, OUT} msm_state_t;
  typedef enum logic [1:0] {A_IDLE, A_INV, A_FIN} add_state_t;

  function automatic logic [P_WIDTH-1:0] fadd(input logic [P_WIDTH-1:0] a,
                                              input logic [P_WIDTH-1:0] b);
    logic [P_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, P_MOD}) s = s - {1'b0, P_MOD};
    return s[P_WIDTH-1:0];
  endfunction

  function automatic logic [P_WIDTH-1:0] fsub(input logic [P_WIDTH-1:0] a,
                                              input logic [P_WIDTH-1:0] b);
    logic [P_WIDTH:0] d;
    d = {1'b0, a} + {1'b0, P_MOD} - {1'b0, b};
    if (d >= {1'b0, P_MOD}) d = d - {1'b0, P_MOD};
    return d[P_WIDTH-1:0];
  endfunction

  function automatic logic [P_WIDTH-1:0] fmul(input logic [P_WIDTH-1:0] a,
                                              input logic [P_WIDTH-1:0] b);
    logic [2*P_WIDTH-1:0] pr;
    pr = ({{P_WIDTH{1'b0}}, a} * {{P_WIDTH{1'b0}}, b}) % {{P_WIDTH{1'b0}}, P_MOD};
    return pr[P_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/ec_point_add.sv
// Affine point adder with start/done handshake; handles P==Q and flags
// an infinite result. Slope denominator is inverted as d^(p-2), one exponent bit per cycle.
module ec_point_add
  import elliptic_curve_structs::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  curve_point_t p,
  input  curve_point_t q,
  output logic         done,
  output curve_point_t r,
  output logic         r_inf
);
  localparam logic [P_WIDTH-1:0] INV_EXP = P_MOD - P_WIDTH'(2);
  localparam int unsigned BW = $clog2(P_WIDTH);

  add_state_t state, state_nx;
  logic [P_WIDTH-1:0] px, py, qx, num, den, inv;
  logic [BW-1:0] bit_idx;
  logic inf_q;

  logic same_x, inf_case;
  logic [P_WIDTH-1:0] px_sq, sq, inv_step, lambda, x3, y3;

  assign same_x   = (p.x == q.x);
  assign inf_case = same_x && (fadd(p.y, q.y) == '0);
  assign px_sq    = fmul(p.x, p.x);
  assign sq       = fmul(inv, inv);
  assign inv_step = INV_EXP[bit_idx] ? fmul(sq, den) : sq;
  assign lambda   = fmul(num, inv);
  assign x3       = fsub(fsub(fmul(lambda, lambda), px), qx);
  assign y3       = fsub(fmul(lambda, fsub(px, x3)), py);

  assign done  = (state == A_FIN);
  assign r     = {x3, y3};
  assign r_inf = inf_q;

  always_comb begin
    state_nx = state;
    case (state)
      A_IDLE:  if (start) state_nx = inf_case ? A_FIN : A_INV;
      A_INV:   if (bit_idx == '0) state_nx = A_FIN;
      A_FIN:   state_nx = A_IDLE;
      default: state_nx = A_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= A_IDLE;
      px      <= '0;
      py      <= '0;
      qx      <= '0;
      num     <= '0;
      den     <= '0;
      inv     <= '0;
      bit_idx <= '0;
      inf_q   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        A_IDLE: if (start) begin
          px      <= p.x;
          py      <= p.y;
          qx      <= q.x;
          inf_q   <= inf_case;
          inv     <= P_WIDTH'(1);
          bit_idx <= BW'(P_WIDTH - 1);
          // tangent slope (3x^2+a)/2y for doubling, chord slope otherwise
          if (same_x) begin
            num <= fadd(fadd(fadd(px_sq, px_sq), px_sq), CURVE_A);
            den <= fadd(p.y, p.y);
          end else begin
            num <= fsub(q.y, p.y);
            den <= fsub(q.x, p.x);
          end
        end
        A_INV: begin
          inv     <= inv_step;
          bit_idx <= bit_idx - BW'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/msm_stream.sv
// Streaming multi-scalar multiplication: accumulates sum(x_i * G_i) over a
// sequence of pairs using MSB-first double-and-add and one shared point adder.
module msm_stream
  import elliptic_curve_structs::*;
#(
  parameter int unsigned SCALAR_W = SCALAR_WIDTH,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                clk,
  input  logic                Reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  curve_point_t        in_G,
  input  logic [SCALAR_W-1:0] in_x,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output curve_point_t        out_R,
  output logic                out_inf,
  output logic [CNT_W-1:0]    out_count
);
  localparam int unsigned IW = (SCALAR_W > 1) ? $clog2(SCALAR_W) : 1;

  msm_state_t state, state_nx;
  curve_point_t g_reg, g_nx, t_pt, t_nx, acc_pt, acc_nx, op_p, op_q, add_r;
  logic [SCALAR_W-1:0] x_reg, x_nx;
  logic [IW-1:0] bit_i, i_nx;
  logic [CNT_W-1:0] count, cnt_nx;
  logic last_reg, last_nx, t_inf, tinf_nx, acc_inf, ainf_nx;
  logic waiting, wait_nx, armed;
  logic add_start, add_done, add_inf;
  logic x_bit, bit_step, acc_step;

  assign x_bit     = x_reg[bit_i];
  assign in_ready  = armed && (state == IDLE);
  assign out_valid = (state == OUT);
  assign out_R     = acc_pt;
  assign out_inf   = acc_inf;
  assign out_count = count;

  ec_point_add adder (
    .clk   (clk),
    .rst_n (Reset_n),
    .start (add_start),
    .p     (op_p),
    .q     (op_q),
    .done  (add_done),
    .r     (add_r),
    .r_inf (add_inf)
  );

  always_comb begin
    state_nx  = state;
    g_nx      = g_reg;
    x_nx      = x_reg;
    last_nx   = last_reg;
    t_nx      = t_pt;
    tinf_nx   = t_inf;
    acc_nx    = acc_pt;
    ainf_nx   = acc_inf;
    i_nx      = bit_i;
    cnt_nx    = count;
    wait_nx   = waiting;
    add_start = 1'b0;
    op_p      = t_pt;
    op_q      = t_pt;
    bit_step  = 1'b0;
    acc_step  = 1'b0;
    case (state)
      IDLE: if (in_valid && in_ready) begin
        g_nx     = in_G;
        x_nx     = in_x;
        last_nx  = in_last;
        t_nx     = '0;
        tinf_nx  = 1'b1;
        i_nx     = IW'(SCALAR_W - 1);
        state_nx = SCAN;
      end
      SCAN: begin
        if (t_inf) begin
          if (x_bit) begin
            t_nx    = g_reg;
            tinf_nx = 1'b0;
          end
          bit_step = 1'b1;
        end else begin
          state_nx = DBL;
        end
      end
      DBL: begin
        if (!waiting) begin
          add_start = 1'b1;
          wait_nx   = 1'b1;
        end else if (add_done) begin
          wait_nx = 1'b0;
          t_nx    = add_r;
          tinf_nx = add_inf;
          if (x_bit) state_nx = ADD;
          else       bit_step = 1'b1;
        end
      end
      ADD: begin
        op_q = g_reg;
        // a doubling that landed on infinity leaves T+G = G without the adder
        if (t_inf) begin
          t_nx     = g_reg;
          tinf_nx  = 1'b0;
          bit_step = 1'b1;
        end else if (!waiting) begin
          add_start = 1'b1;
          wait_nx   = 1'b1;
        end else if (add_done) begin
          wait_nx  = 1'b0;
          t_nx     = add_r;
          tinf_nx  = add_inf;
          bit_step = 1'b1;
        end
      end
      ACC: begin
        op_p = acc_pt;
        op_q = t_pt;
        if (t_inf) begin
          acc_step = 1'b1;
        end else if (acc_inf) begin
          acc_nx   = t_pt;
          ainf_nx  = 1'b0;
          acc_step = 1'b1;
        end else if (!waiting) begin
          add_start = 1'b1;
          wait_nx   = 1'b1;
        end else if (add_done) begin
          wait_nx  = 1'b0;
          acc_nx   = add_r;
          ainf_nx  = add_inf;
          acc_step = 1'b1;
        end
      end
      OUT: if (out_ready) begin
        acc_nx   = '0;
        ainf_nx  = 1'b1;
        cnt_nx   = '0;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (bit_step) begin
      if (bit_i == '0) begin
        state_nx = ACC;
      end else begin
        i_nx     = bit_i - IW'(1);
        state_nx = SCAN;
      end
    end
    if (acc_step) begin
      cnt_nx   = count + CNT_W'(1);
      state_nx = last_reg ? OUT : IDLE;
    end
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      g_reg    <= '0;
      x_reg    <= '0;
      last_reg <= 1'b0;
      t_pt     <= '0;
      t_inf    <= 1'b1;
      acc_pt   <= '0;
      acc_inf  <= 1'b1;
      bit_i    <= '0;
      count    <= '0;
      waiting  <= 1'b0;
    end else begin
      state    <= state_nx;
      armed    <= 1'b1;
      g_reg    <= g_nx;
      x_reg    <= x_nx;
      last_reg <= last_nx;
      t_pt     <= t_nx;
      t_inf    <= tinf_nx;
      acc_pt   <= acc_nx;
      acc_inf  <= ainf_nx;
      bit_i    <= i_nx;
      count    <= cnt_nx;
      waiting  <= wait_nx;
    end
  end
endmodule

// File: tb/tb_msm_stream.sv
// Scoreboard bench for msm_stream: group-law reference model in integer
// arithmetic, scalar products by repeated addition.
`timescale 1ns/1ps
module tb_msm_stream;
  import elliptic_curve_structs::*;

  localparam int unsigned SW     = SCALAR_WIDTH;
  localparam int unsigned CW     = 16;
  localparam int          PRIME  = 251;
  localparam int          A_COEF = 1;
  localparam int          NPAIRS = 100;
  localparam int unsigned LIMIT  = 5000;

  typedef struct { int x; int y; bit inf; } mpt_t;
  typedef struct { mpt_t r; int unsigned cnt; } exp_t;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  curve_point_t in_G = '0;
  logic [SW-1:0] in_x = '0;
  logic in_ready, out_valid, out_inf;
  curve_point_t out_R;
  logic [CW-1:0] out_count;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned add_starts = 0;
  int unsigned accept_cyc = 0;
  exp_t sb[$];
  mpt_t tg[NPAIRS];
  int tx[NPAIRS];
  mpt_t full_r;

  msm_stream #(.SCALAR_W(SW), .CNT_W(CW)) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_G      (in_G),
    .in_x      (in_x),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_R     (out_R),
    .out_inf   (out_inf),
    .out_count (out_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (Reset_n && dut.add_start === 1'b1) add_starts <= add_starts + 1;

  function automatic int md(input int a);
    int r;
    r = a % PRIME;
    return (r < 0) ? r + PRIME : r;
  endfunction

  function automatic int minv(input int a);
    int t, nt, r, nr, q, tmp;
    t = 0; nt = 1; r = PRIME; nr = md(a);
    while (nr != 0) begin
      q = r / nr;
      tmp = t - q * nt; t = nt; nt = tmp;
      tmp = r - q * nr; r = nr; nr = tmp;
    end
    return md(t);
  endfunction

  function automatic mpt_t inf_pt();
    mpt_t r;
    r.x = 0; r.y = 0; r.inf = 1'b1;
    return r;
  endfunction

  function automatic mpt_t padd(input mpt_t a, input mpt_t b);
    mpt_t res;
    int lam;
    if (a.inf) return b;
    if (b.inf) return a;
    if (a.x == b.x && md(a.y + b.y) == 0) return inf_pt();
    if (a.x == b.x) lam = md(md(3 * a.x * a.x + A_COEF) * minv(2 * a.y));
    else            lam = md(md(b.y - a.y) * minv(b.x - a.x));
    res.inf = 1'b0;
    res.x = md(lam * lam - a.x - b.x);
    res.y = md(lam * md(a.x - res.x) - a.y);
    return res;
  endfunction

  function automatic mpt_t smul(input mpt_t g, input int k);
    mpt_t r;
    r = inf_pt();
    for (int n = 0; n < k; n++) r = padd(r, g);
    return r;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_R"}, out_R, 0);
    chk({tag, "_out_inf"}, out_inf, 1);
    chk({tag, "_out_count"}, out_count, 0);
  endtask

  task automatic push_exp(input mpt_t r, input int unsigned cnt);
    exp_t e;
    e.r = r;
    e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic send_pair(input mpt_t g, input int x, input bit last);
    int unsigned n;
    n = 0;
    @(negedge clk);
    in_G.x = P_WIDTH'(g.x);
    in_G.y = P_WIDTH'(g.y);
    in_x = SW'(x);
    in_last = last;
    in_valid = 1'b1;
    while (!in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
      in_valid = 1'b0;
      return;
    end
    accept_cyc = cyc + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_G = curve_point_t'($urandom);
    in_x = SW'($urandom);
    in_last = 1'($urandom);
  endtask

  task automatic wait_out(input string name);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < LIMIT);
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL %s: out_valid=0 after %0d cycles, required 1", name, n);
    end
  endtask

  task automatic wait_drain(input string name);
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: %0d results still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic run_full();
    push_exp(full_r, NPAIRS);
    for (int i = 0; i < NPAIRS; i++) begin
      send_pair(tg[i], tx[i], i == NPAIRS - 1);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  // Monitor: every cycle a result is offered it must match the scoreboard head.
  always @(negedge clk) begin
    if (Reset_n && out_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: out_valid=1 count=%0d inf=%0b, required no result", out_count, out_inf);
      end else begin
        if (out_inf !== sb[0].r.inf || int'(out_count) != int'(sb[0].cnt) ||
            (!sb[0].r.inf && (int'(out_R.x) != sb[0].r.x || int'(out_R.y) != sb[0].r.y))) begin
          errors++;
          $display("FAIL result: got inf=%0b R=(%0d,%0d) count=%0d, required inf=%0b R=(%0d,%0d) count=%0d",
                   out_inf, out_R.x, out_R.y, out_count,
                   sb[0].r.inf, sb[0].r.x, sb[0].r.y, sb[0].cnt);
        end
        if (out_ready) sb.delete(0);
      end
    end
  end

  initial begin
    mpt_t base, p, g0, ng0, acc_m;
    int xs[3];
    int xb;
    int unsigned st0;

    base.x = 1; base.y = 1; base.inf = 1'b0;
    for (int i = 0; i < NPAIRS; i++) begin
      do p = smul(base, int'($urandom_range(1, PRIME - 1))); while (p.inf);
      tg[i] = p;
      tx[i] = int'($urandom_range(0, (1 << SW) - 1));
    end
    full_r = inf_pt();
    for (int i = 0; i < NPAIRS; i++) full_r = padd(full_r, smul(tg[i], tx[i]));
    g0 = tg[0];

    @(negedge clk);
    check_reset("reset");
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    chk("ready_at_deassert", in_ready, 0);
    @(posedge clk);
    #1;
    chk("ready_first_edge", in_ready, 1);

    // Zero scalar: no adder calls, SCALAR_W scan cycles plus ACC.
    st0 = add_starts;
    push_exp(inf_pt(), 1);
    send_pair(g0, 0, 1'b1);
    wait_out("zero_scalar");
    chk("zero_latency", cyc - accept_cyc, SW + 1);
    chk("zero_adder_starts", add_starts - st0, 0);
    @(posedge clk);
    #1;
    chk("ready_after_out", in_ready, 1);
    chk("valid_after_out", out_valid, 0);
    chk("count_after_out", out_count, 0);
    chk("inf_after_out", out_inf, 1);

    push_exp(g0, 1);
    send_pair(g0, 1, 1'b1);
    wait_drain("unit_scalar");

    ng0 = g0;
    ng0.y = md(-g0.y);
    push_exp(padd(g0, ng0), 2);
    send_pair(g0, 1, 1'b0);
    send_pair(ng0, 1, 1'b1);
    wait_drain("cancel_pair");

    acc_m = inf_pt();
    for (int k = 0; k < 3; k++) begin
      xs[k] = int'($urandom_range(1, (1 << SW) - 1));
      acc_m = padd(acc_m, smul(tg[k + 1], xs[k]));
    end
    xb = int'($urandom_range(1, (1 << SW) - 1));
    push_exp(acc_m, 3);
    push_exp(smul(tg[4], xb), 1);
    for (int k = 0; k < 3; k++) send_pair(tg[k + 1], xs[k], k == 2);
    send_pair(tg[4], xb, 1'b1);
    wait_drain("back_to_back");

    out_ready = 1'b0;
    run_full();
    wait_out("full_stalled");
    repeat (50) @(negedge clk);
    out_ready = 1'b1;
    wait_drain("full_stalled");

    for (int i = 0; i < 40; i++) send_pair(tg[i], tx[i], 1'b0);
    repeat (5) @(negedge clk);
    Reset_n = 1'b0;
    #1;
    check_reset("midreset");
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("ready_after_midreset", in_ready, 1);
    chk("no_result_after_midreset", out_valid, 0);
    run_full();
    wait_drain("full_rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
